// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file and its scoreboard.
// Contents: default widths, the hard-wired zero-register index, address/data word types.
// Optional feature macro used by regfile_sb: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 5;

  // Register 0 always reads zero and can never be reserved.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking outstanding producers.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   write_en_i/write_reg_i writeback write; clears the busy bit of the written register
//   reserve_i/reserve_reg_i decode reservation request
//   flush_i                synchronous clear of every busy bit (beats reserve)
//   busy_o                 busy vector (bit 0 is always 0)
//   reserve_ok_o           combinational accept of the current reservation
//   pending_count_o        registered count of busy registers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] write_reg_i,
  input  logic              reserve_i,
  input  logic [ADDR_W-1:0] reserve_reg_i,
  input  logic              flush_i,
  output logic [DEPTH-1:0]  busy_o,
  output logic              reserve_ok_o,
  output logic [ADDR_W:0]   pending_count_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             wr_hit, rsv_nz, rsv_ok_c, rsv_set, inc, dec;

  // Next busy vector and pending count.
  always_comb begin
    wr_hit   = write_en_i && (write_reg_i != ZERO_ADDR);
    rsv_nz   = reserve_reg_i != ZERO_ADDR;
    // Gated by reset so the output reads 0 while held in reset.
    rsv_ok_c = rst_ni && reserve_i &&
               (!rsv_nz || !busy_q[reserve_reg_i] ||
                (write_en_i && (write_reg_i == reserve_reg_i)));
    rsv_set  = rsv_ok_c && rsv_nz && !flush_i;
    inc      = rsv_set && !busy_q[reserve_reg_i];
    // A write to a busy register that is re-reserved in the same cycle keeps it busy.
    dec      = wr_hit && busy_q[write_reg_i] &&
               !(rsv_set && (reserve_reg_i == write_reg_i));

    busy_d = busy_q;
    if (wr_hit) busy_d[write_reg_i] = 1'b0;
    if (rsv_set) busy_d[reserve_reg_i] = 1'b1;
    if (flush_i) busy_d = '0;

    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (inc && !dec) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (dec && !inc) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o          = busy_q;
  assign reserve_ok_o    = rsv_ok_c;
  assign pending_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file (2 read ports, 1 write port, fixed monitor port) with a
// busy scoreboard for stalling decode on outstanding producers. Register 0 reads 0.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   Read1/Read2 -> Data1/Data2, Busy1/Busy2   combinational reads
//   Data3                     contents of MON_REG
//   WriteReg/WriteData/RegWrite  writeback port (also clears busy)
//   Reserve/ReserveReg -> ReserveOk   decode reservation
//   Flush                     clear all busy bits
//   PendingCount              number of busy registers
// Build option: REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MON_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              Busy1,
  output logic              Busy2,
  output logic [DATA_W-1:0] Data3,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveReg,
  output logic              ReserveOk,
  input  logic              Flush,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] MON_ADDR  = ADDR_W'(MON_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_hit;

  assign wr_hit = RegWrite && (WriteReg != ZERO_ADDR);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i           (clock),
    .rst_ni          (reset_n),
    .write_en_i      (RegWrite),
    .write_reg_i     (WriteReg),
    .reserve_i       (Reserve),
    .reserve_reg_i   (ReserveReg),
    .flush_i         (Flush),
    .busy_o          (busy),
    .reserve_ok_o    (ReserveOk),
    .pending_count_o (PendingCount)
  );

  // Storage; register 0 is never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  // Read muxing.
  always_comb begin
    Data1 = (Read1 == ZERO_ADDR) ? '0 : regs_q[Read1];
    Data2 = (Read2 == ZERO_ADDR) ? '0 : regs_q[Read2];
    Data3 = (MON_ADDR == ZERO_ADDR) ? '0 : regs_q[MON_ADDR];
    Busy1 = busy[Read1];
    Busy2 = busy[Read2];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; gated so reads stay 0 while in reset.
    if (reset_n && wr_hit) begin
      if (Read1 == WriteReg) begin
        Data1 = WriteData;
        Busy1 = 1'b0;
      end
      if (Read2 == WriteReg) begin
        Data2 = WriteData;
        Busy2 = 1'b0;
      end
      if (MON_ADDR == WriteReg) Data3 = WriteData;
    end
`endif
  end

endmodule
